// File: rtl/tdm_mux_if.sv
// Channel-select bus for tdm_mux_scanner: packed channel data and mode controls in, selected data out.
// The ch_mask signal exists only when MUX_CH_MASK_EN is defined.
interface tdm_mux_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 1
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH*WIDTH-1:0] din;
  logic [SEL_W-1:0]        sel;
  logic                    mode;
  logic                    hold;
`ifdef MUX_CH_MASK_EN
  logic [NUM_CH-1:0]       ch_mask;
`endif
  logic [WIDTH-1:0]        y;
  logic [SEL_W-1:0]        ch;
  logic                    ch_change;

`ifdef MUX_CH_MASK_EN
  modport master (output din, sel, mode, hold, ch_mask, input y, ch, ch_change);
  modport slave  (input din, sel, mode, hold, ch_mask, output y, ch, ch_change);
`else
  modport master (output din, sel, mode, hold, input y, ch, ch_change);
  modport slave  (input din, sel, mode, hold, output y, ch, ch_change);
`endif
endinterface

// File: rtl/tdm_mux_scanner.sv
// NUM_CH-to-1 registered mux with manual select and round-robin auto-scan with dwell/hold.
// Define MUX_CH_MASK_EN to add the ch_mask port and skip disabled channels while scanning.
module tdm_mux_scanner #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 1,
  parameter int DWELL  = 50
) (
  input  logic     clk,
  input  logic     reset,
  tdm_mux_if.slave bus
);
  localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  typedef enum logic [1:0] {
    S_MAN  = 2'd0,
    S_SCAN = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [SEL_W-1:0]  ch_r;
  logic [SEL_W-1:0]  ch_next_s;
  logic [CNT_W-1:0]  dwell_cnt_r;
  logic [CNT_W-1:0]  cnt_base_s;
  logic [CNT_W-1:0]  cnt_next_s;
  logic [WIDTH-1:0]  y_r;
  logic              ch_change_r;
  logic [NUM_CH-1:0] mask_s;
  logic [WIDTH-1:0]  din_arr_s [NUM_CH];

  // First enabled channel after cur in increasing, wrapping order; cur itself if no other is enabled.
  function automatic logic [SEL_W-1:0] next_enabled(input logic [SEL_W-1:0] cur,
                                                    input logic [NUM_CH-1:0] mask);
    logic [SEL_W-1:0] res;
    int idx;
    res = cur;
    for (int k = NUM_CH - 1; k >= 1; k--) begin
      idx = (int'(cur) + k) % NUM_CH;
      if (mask[SEL_W'(idx)]) begin
        res = SEL_W'(idx);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

`ifdef MUX_CH_MASK_EN
  assign mask_s = bus.ch_mask;
`else
  assign mask_s = {NUM_CH{1'b1}};
`endif

  // Unpack the channel bus into an array indexed by channel number.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      din_arr_s[k] = bus.din[k*WIDTH +: WIDTH];
    end
  end

  // Decode mode/hold into the governing state and choose next channel and dwell count.
  always_comb begin
    state_s    = S_MAN;
    cnt_base_s = dwell_cnt_r;
    ch_next_s  = ch_r;
    cnt_next_s = {CNT_W{1'b0}};
    if (bus.mode == 1'b0) begin
      state_s = S_MAN;
    end else if (bus.hold == 1'b1) begin
      state_s = S_HOLD;
    end else begin
      state_s = S_SCAN;
    end
    // A scan entered from manual always begins a fresh dwell on the current channel.
    if (state_r == S_MAN) begin
      cnt_base_s = {CNT_W{1'b0}};
    end else begin
      cnt_base_s = dwell_cnt_r;
    end
    case (state_s)
      S_MAN: begin
        cnt_next_s = {CNT_W{1'b0}};
        if (int'(bus.sel) < NUM_CH) begin
          ch_next_s = bus.sel;
        end else begin
          ch_next_s = ch_r;
        end
      end
      S_SCAN: begin
        if (mask_s == {NUM_CH{1'b0}}) begin
          ch_next_s  = ch_r;
          cnt_next_s = cnt_base_s;
        end else if (cnt_base_s == DWELL_LAST) begin
          ch_next_s  = next_enabled(ch_r, mask_s);
          cnt_next_s = {CNT_W{1'b0}};
        end else begin
          ch_next_s  = ch_r;
          cnt_next_s = cnt_base_s + CNT_W'(1'b1);
        end
      end
      S_HOLD: begin
        ch_next_s  = ch_r;
        cnt_next_s = dwell_cnt_r;
      end
      default: begin
        ch_next_s  = ch_r;
        cnt_next_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // Register state, channel, dwell count, selected data and change strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_MAN;
      ch_r        <= {SEL_W{1'b0}};
      dwell_cnt_r <= {CNT_W{1'b0}};
      y_r         <= {WIDTH{1'b0}};
      ch_change_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      ch_r        <= ch_next_s;
      dwell_cnt_r <= cnt_next_s;
      y_r         <= din_arr_s[ch_next_s];
      ch_change_r <= (ch_next_s != ch_r);
    end
  end

  assign bus.y         = y_r;
  assign bus.ch        = ch_r;
  assign bus.ch_change = ch_change_r;
endmodule

// File: tb/tb_tdm_mux_scanner.sv
// Directed plus randomized bench for tdm_mux_scanner against a channel/dwell reference model.
// Build with MUX_CH_MASK_EN defined to also exercise channel masking.
module tb_tdm_mux_scanner;
  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;
  localparam int DWELL  = 3;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  // reference model state: channel, cycles already spent on it, expected outputs
  int         m_ch;
  int         m_cnt;
  logic [7:0] m_y;
  logic       m_chg;
  logic       m_y1;

  tdm_mux_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bus ();
  tdm_mux_if #(.NUM_CH(NUM_CH), .WIDTH(1))     bus1 ();

  tdm_mux_scanner #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DWELL(DWELL)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  tdm_mux_scanner #(.NUM_CH(NUM_CH), .WIDTH(1), .DWELL(DWELL)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Predict the effect of the next edge from the present inputs, clock it, compare.
  task automatic tick(input string tag);
    int nc;
    logic [3:0] mk;
`ifdef MUX_CH_MASK_EN
    mk = bus.ch_mask;
`else
    mk = 4'hF;
`endif
    nc = m_ch;
    if (reset) begin
      m_ch = 0; m_cnt = 0; m_y = 8'h00; m_chg = 1'b0; m_y1 = 1'b0;
    end else begin
      if (!bus.mode) begin
        nc = int'(bus.sel);
        m_cnt = 0;
      end else if (!bus.hold && mk != 4'h0) begin
        if (m_cnt == DWELL - 1) begin
          m_cnt = 0;
          for (int k = 1; k < NUM_CH; k++) begin
            if (mk[(m_ch + k) % NUM_CH]) begin
              nc = (m_ch + k) % NUM_CH;
              break;
            end
          end
        end else begin
          m_cnt++;
        end
      end
      m_chg = (nc != m_ch);
      m_ch  = nc;
      m_y   = bus.din[nc*8 +: 8];
      m_y1  = bus1.din[bus1.sel];
    end
    @(posedge clk);
    #1;
    chk({tag, "_ch"}, 32'(bus.ch), 32'(m_ch));
    chk({tag, "_y"}, 32'(bus.y), 32'(m_y));
    chk({tag, "_chg"}, 32'(bus.ch_change), 32'(m_chg));
    chk({tag, "_y1"}, 32'(bus1.y), 32'(m_y1));
  endtask

  initial begin
    int seq [13];
    seq = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
    m_ch = 0; m_cnt = 0; m_y = 8'h00; m_chg = 1'b0; m_y1 = 1'b0;
    reset = 1'b1;
    bus.din = 32'hDDCCBBAA; bus.sel = 2'd0; bus.mode = 1'b0; bus.hold = 1'b0;
    bus1.din = 4'h0; bus1.sel = 2'd0; bus1.mode = 1'b0; bus1.hold = 1'b0;
`ifdef MUX_CH_MASK_EN
    bus.ch_mask = 4'hF; bus1.ch_mask = 4'hF;
`endif
    // reset held two cycles
    tick("reset");
    tick("reset");
    reset = 1'b0;

    // manual select walk
    for (int s = 0; s < NUM_CH; s++) begin
      bus.sel = 2'(s);
      tick("manual");
    end

    // scan from channel 0: literal channel sequence
    bus.sel = 2'd0;
    tick("scan_pre");
    chk("scan_seq0", 32'(bus.ch), 32'(seq[0]));
    bus.mode = 1'b1;
    for (int i = 1; i < 13; i++) begin
      bus.din = $urandom;
      tick("scan");
      chk("scan_seq", 32'(bus.ch), 32'(seq[i]));
    end

    // reach first cycle on ch 1, hold 5 cycles, then resume remaining dwell
    for (int i = 0; i < 3; i++) tick("pre_hold");
    chk("hold_entry", 32'(bus.ch), 32'd1);
    bus.hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.din = $urandom;
      tick("hold");
    end
    bus.hold = 1'b0;
    tick("resume");
    chk("resume_a", 32'(bus.ch), 32'd1);
    tick("resume");
    chk("resume_b", 32'(bus.ch), 32'd1);
    tick("resume");
    chk("resume_c", 32'(bus.ch), 32'd2);

    // reset mid-dwell while scanning on ch 2
    tick("scan2");
    reset = 1'b1;
    tick("scan_rst");
    reset = 1'b0;
    tick("post_rst");
    chk("post_rst_a", 32'(bus.ch), 32'd0);
    tick("post_rst");
    chk("post_rst_b", 32'(bus.ch), 32'd0);
    tick("post_rst");
    chk("post_rst_c", 32'(bus.ch), 32'd1);

    // legacy 4:1 truth table on the one-bit instance
    bus.mode = 1'b0;
    for (int p = 0; p < 16; p++) begin
      for (int s = 0; s < 4; s++) begin
        bus1.din = 4'(p);
        bus1.sel = 2'(s);
        tick("legacy");
      end
    end

`ifdef MUX_CH_MASK_EN
    // masked scan 1,3,1,... then everything masked off
    bus.sel = 2'd0;
    tick("mask_pre");
    bus.ch_mask = 4'b1010;
    bus.mode = 1'b1;
    for (int i = 0; i < 12; i++) tick("mask");
    bus.ch_mask = 4'b0000;
    for (int i = 0; i < 6; i++) tick("mask_off");
    bus.ch_mask = 4'hF;
`endif

    // randomized mode/hold/sel/data with occasional reset
    for (int i = 0; i < 300; i++) begin
      bus.din  = $urandom;
      bus.sel  = 2'($urandom_range(0, 3));
      bus.mode = ($urandom_range(0, 5) != 0);
      bus.hold = ($urandom_range(0, 3) == 0);
      bus1.din = 4'($urandom_range(0, 15));
      bus1.sel = 2'($urandom_range(0, 3));
      reset    = ($urandom_range(0, 39) == 0);
`ifdef MUX_CH_MASK_EN
      if ($urandom_range(0, 9) == 0) bus.ch_mask = 4'($urandom_range(0, 15));
`endif
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
